hdma_ctrl: RTL and testbench

- Colour-mode VRAM DMA controller, MMIO registers FF51–FF55.
- Copies 16-byte blocks from any source address into VRAM (0x8000–0x9FFF).
- Two modes:
  - General-purpose (GDMA): the whole length runs in one burst.
  - HBlank (HDMA): one 16-byte block per HBlank entry.
- Acts as a second bus master beside OAM DMA. While it owns the bus it asserts hdma_halt; the top level stalls the CPU and muxes hdma_a/rd/wr/dout onto the main bus.

---
 rtl/hdma_ctrl_if.sv | 28 ++
 rtl/hdma_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hdma_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdma_ctrl_if.sv
// Bus bundle for the VRAM DMA controller: CPU-side MMIO register port,
// HBlank/LCD status inputs and the second-master bus the controller drives.
// The slave modport is the controller's view; master is the top level's view.
interface hdma_ctrl_if;
  logic [15:0] mmio_a;
  logic [7:0]  mmio_din;
  logic        mmio_wr;
  logic [7:0]  mmio_dout;
  logic        hblank;
  logic        lcd_on;
  logic [15:0] hdma_a;
  logic        hdma_rd;
  logic        hdma_wr;
  logic [7:0]  hdma_din;
  logic [7:0]  hdma_dout;
  logic        hdma_halt;
  logic        hdma_active;

  modport slave (
    input  mmio_a, mmio_din, mmio_wr, hblank, lcd_on, hdma_din,
    output mmio_dout, hdma_a, hdma_rd, hdma_wr, hdma_dout, hdma_halt, hdma_active
  );

  modport master (
    output mmio_a, mmio_din, mmio_wr, hblank, lcd_on, hdma_din,
    input  mmio_dout, hdma_a, hdma_rd, hdma_wr, hdma_dout, hdma_halt, hdma_active
  );
endinterface

// File: rtl/hdma_ctrl.sv
// Colour-mode VRAM DMA controller (FF51-FF55). Copies 16-byte blocks from
// any source address into VRAM, either all at once (GDMA) or one block per
// HBlank entry (HDMA). Each byte takes RD_CYCLES read clocks plus one write
// clock; while a block is moving the controller owns the bus and halts the CPU.
module hdma_ctrl #(
  parameter int RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  hdma_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GDMA_RUN  = 2'd1,
    HDMA_WAIT = 2'd2,
    HDMA_RUN  = 2'd3
  } state_t;

  localparam int             CW      = $clog2(RD_CYCLES + 1);
  localparam logic [CW-1:0]  LAST_RD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0]  WR_CYC  = CW'(RD_CYCLES);

  state_t        r_state;
  state_t        w_nextState;
  logic [15:0]   r_src;
  logic [12:0]   r_dst;
  logic [6:0]    r_len;
  logic          r_hblankQ;
  logic [CW-1:0] r_cyc;
  logic [3:0]    r_byteCnt;
  logic [7:0]    r_data;

  logic w_wrFF51;
  logic w_wrFF52;
  logic w_wrFF53;
  logic w_wrFF54;
  logic w_wrFF55;
  logic w_hblankRise;
  logic w_running;
  logic w_wrPhase;
  logic w_blockEnd;

  assign w_wrFF51     = bus.mmio_wr && (bus.mmio_a == 16'hFF51);
  assign w_wrFF52     = bus.mmio_wr && (bus.mmio_a == 16'hFF52);
  assign w_wrFF53     = bus.mmio_wr && (bus.mmio_a == 16'hFF53);
  assign w_wrFF54     = bus.mmio_wr && (bus.mmio_a == 16'hFF54);
  assign w_wrFF55     = bus.mmio_wr && (bus.mmio_a == 16'hFF55);
  assign w_hblankRise = bus.hblank && !r_hblankQ && bus.lcd_on;
  assign w_running    = (r_state == GDMA_RUN) || (r_state == HDMA_RUN);
  assign w_wrPhase    = w_running && (r_cyc == WR_CYC);
  assign w_blockEnd   = w_wrPhase && (r_byteCnt == 4'hF);

  // State register; reset aborts any transfer at once and drops the halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and bus outputs; a terminate write beats a same-clock HBlank edge.
  always_comb begin
    w_nextState     = r_state;
    bus.hdma_a      = 16'h0000;
    bus.hdma_rd     = 1'b0;
    bus.hdma_wr     = 1'b0;
    bus.hdma_dout   = 8'h00;
    bus.hdma_halt   = 1'b0;
    bus.hdma_active = 1'b0;
    if (w_running) begin
      bus.hdma_halt = 1'b1;
      if (w_wrPhase) begin
        bus.hdma_a    = {3'b100, r_dst};
        bus.hdma_wr   = 1'b1;
        bus.hdma_dout = r_data;
      end else begin
        bus.hdma_a  = r_src;
        bus.hdma_rd = 1'b1;
      end
    end
    case (r_state)
      IDLE: begin
        if (w_wrFF55) begin
          w_nextState = bus.mmio_din[7] ? HDMA_WAIT : GDMA_RUN;
        end
      end
      GDMA_RUN: begin
        if (w_blockEnd && (r_len == 7'h00)) begin
          w_nextState = IDLE;
        end
      end
      HDMA_WAIT: begin
        bus.hdma_active = 1'b1;
        if (w_wrFF55 && !bus.mmio_din[7]) begin
          w_nextState = IDLE;
        end else if (w_hblankRise) begin
          w_nextState = HDMA_RUN;
        end
      end
      HDMA_RUN: begin
        bus.hdma_active = 1'b1;
        if (w_blockEnd) begin
          w_nextState = (r_len == 7'h00) ? IDLE : HDMA_WAIT;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Address/length registers, byte sequencing and the HBlank edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src     <= 16'h0000;
      r_dst     <= 13'h0000;
      r_len     <= 7'h7F;
      r_hblankQ <= 1'b0;
      r_cyc     <= '0;
      r_byteCnt <= 4'h0;
      r_data    <= 8'h00;
    end else begin
      r_hblankQ <= bus.hblank;
      if (w_running) begin
        if (w_wrPhase) begin
          r_cyc     <= '0;
          r_src     <= r_src + 16'h0001;
          r_dst     <= r_dst + 13'h0001;
          r_byteCnt <= r_byteCnt + 4'h1;
          if (r_byteCnt == 4'hF) begin
            r_len <= r_len - 7'h01;
          end
        end else begin
          r_cyc <= r_cyc + CW'(1);
          if (r_cyc == LAST_RD) begin
            r_data <= bus.hdma_din;
          end
        end
      end else begin
        r_cyc     <= '0;
        r_byteCnt <= 4'h0;
        if (w_wrFF51) begin
          r_src[15:8] <= bus.mmio_din;
        end
        if (w_wrFF52) begin
          r_src[7:0] <= {bus.mmio_din[7:4], 4'h0};
        end
        if (w_wrFF53) begin
          r_dst[12:8] <= bus.mmio_din[4:0];
        end
        if (w_wrFF54) begin
          r_dst[7:0] <= {bus.mmio_din[7:4], 4'h0};
        end
        if (w_wrFF55 && (r_state == IDLE)) begin
          r_len <= bus.mmio_din[6:0];
        end
      end
    end
  end

  // Register read mux; only FF55 returns state, the address registers read as 0xFF.
  always_comb begin
    bus.mmio_dout = 8'hFF;
    if (bus.mmio_a == 16'hFF55) begin
      bus.mmio_dout = {(r_state == IDLE), r_len};
    end
  end

endmodule

// File: tb/tb_hdma_ctrl.sv
// Scoreboard bench for hdma_ctrl: stimulus pushes the expected VRAM write
// beats into a queue, a monitor pops and compares every bus write it sees.
module tb_hdma_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic clk;
  logic rst;
  hdma_ctrl_if busIf();

  hdma_ctrl #(.RD_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  beat_t expQ[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    haltCycles  = 0;
  int    writesSeen  = 0;

  // Source memory contents are a fixed function of the address.
  function automatic logic [7:0] memByte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory with a registered output, like a synchronous RAM.
  always @(posedge clk) busIf.hdma_din <= memByte(busIf.hdma_a);

  // Monitor: counts halt cycles and scores every bus write beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (busIf.hdma_halt) haltCycles++;
      if (busIf.hdma_wr) begin
        writesSeen++;
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_write got addr=%h data=%h, none expected",
                   busIf.hdma_a, busIf.hdma_dout);
        end else begin
          e = expQ.pop_front();
          if (busIf.hdma_a !== e.addr || busIf.hdma_dout !== e.data) begin
            miscompares++;
            $display("[TB] FAIL write_beat got addr=%h data=%h, expected addr=%h data=%h",
                     busIf.hdma_a, busIf.hdma_dout, e.addr, e.data);
          end
        end
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    busIf.mmio_a   = addr;
    busIf.mmio_din = data;
    busIf.mmio_wr  = 1'b1;
    @(posedge clk); #1;
    busIf.mmio_wr  = 1'b0;
  endtask

  task automatic readReg(input logic [15:0] addr, output logic [7:0] data);
    busIf.mmio_a = addr;
    #1;
    data = busIf.mmio_dout;
  endtask

  task automatic setSrcDst(input logic [7:0] s1, input logic [7:0] s2,
                           input logic [7:0] d1, input logic [7:0] d2);
    applyStimulus(16'hFF51, s1);
    applyStimulus(16'hFF52, s2);
    applyStimulus(16'hFF53, d1);
    applyStimulus(16'hFF54, d2);
  endtask

  task automatic expectBlock(input logic [15:0] src, input logic [15:0] dst, input int nBytes);
    beat_t b;
    for (int i = 0; i < nBytes; i++) begin
      b.addr = 16'h8000 | ((dst + 16'(i)) & 16'h1FFF);
      b.data = memByte(src + 16'(i));
      expQ.push_back(b);
    end
  endtask

  task automatic waitHaltDone(input int maxCycles, input string name);
    int n = 0;
    while (!busIf.hdma_halt && n < maxCycles) begin @(posedge clk); #1; n++; end
    while (busIf.hdma_halt && n < maxCycles) begin @(posedge clk); #1; n++; end
    if (n >= maxCycles) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout got %0d cycles, expected halt to finish", name, n);
    end
  endtask

  task automatic idleWindow(input int n, input string name);
    int busy = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (busIf.hdma_rd || busIf.hdma_wr || busIf.hdma_halt) busy++;
    end
    checkOutput(name, busy, 0);
  endtask

  task automatic hblankBlock(input string name);
    int base = haltCycles;
    @(posedge clk); #1;
    busIf.hblank = 1'b1;
    waitHaltDone(200, name);
    busIf.hblank = 1'b0;
    @(posedge clk); #1;
    checkOutput(name, haltCycles - base, 48);
  endtask

  initial begin
    logic [7:0] rv;
    int base;
    busIf.mmio_a   = 16'h0000;
    busIf.mmio_din = 8'h00;
    busIf.mmio_wr  = 1'b0;
    busIf.hblank   = 1'b0;
    busIf.lcd_on   = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_halt", int'(busIf.hdma_halt), 0);
    checkOutput("rst_active", int'(busIf.hdma_active), 0);
    checkOutput("rst_rdwr", int'({busIf.hdma_rd, busIf.hdma_wr}), 0);
    readReg(16'hFF55, rv); checkOutput("rst_ff55", int'(rv), 'hFF);
    readReg(16'hFF51, rv); checkOutput("rst_ff51", int'(rv), 'hFF);

    $display("[TB] GDMA basic");
    setSrcDst(8'hC0, 8'h00, 8'h00, 8'h00);
    expectBlock(16'hC000, 16'h8000, 16);
    base = haltCycles;
    applyStimulus(16'hFF55, 8'h00);
    waitHaltDone(200, "gdma_basic_done");
    checkOutput("gdma_basic_halt", haltCycles - base, 48);
    readReg(16'hFF55, rv); checkOutput("gdma_basic_ff55", int'(rv), 'hFF);
    readReg(16'hFF52, rv); checkOutput("gdma_basic_ff52", int'(rv), 'hFF);
    checkOutput("gdma_basic_queue", expQ.size(), 0);

    $display("[TB] HDMA two blocks");
    setSrcDst(8'hC1, 8'h00, 8'h01, 8'h00);
    applyStimulus(16'hFF55, 8'h81);
    checkOutput("hdma_active_wait", int'(busIf.hdma_active), 1);
    readReg(16'hFF55, rv); checkOutput("hdma_ff55_a", int'(rv), 'h01);
    idleWindow(20, "hdma_no_activity");
    expectBlock(16'hC100, 16'h8100, 16);
    hblankBlock("hdma_block1_halt");
    readReg(16'hFF55, rv); checkOutput("hdma_ff55_b", int'(rv), 'h00);
    expectBlock(16'hC110, 16'h8110, 16);
    hblankBlock("hdma_block2_halt");
    readReg(16'hFF55, rv); checkOutput("hdma_ff55_c", int'(rv), 'hFF);
    checkOutput("hdma_active_done", int'(busIf.hdma_active), 0);
    checkOutput("hdma_queue", expQ.size(), 0);

    $display("[TB] HDMA terminate and ignored FF55");
    setSrcDst(8'hC2, 8'h00, 8'h02, 8'h00);
    applyStimulus(16'hFF55, 8'h83);
    expectBlock(16'hC200, 16'h8200, 16);
    hblankBlock("term_block_halt");
    applyStimulus(16'hFF55, 8'h85);
    readReg(16'hFF55, rv); checkOutput("term_ignore_85", int'(rv), 'h02);
    applyStimulus(16'hFF55, 8'h00);
    readReg(16'hFF55, rv); checkOutput("term_ff55", int'(rv), 'h82);
    busIf.hblank = 1'b1;
    idleWindow(20, "term_no_xfer_a");
    busIf.hblank = 1'b0;
    idleWindow(5, "term_no_xfer_b");
    busIf.hblank = 1'b1;
    idleWindow(20, "term_no_xfer_c");
    busIf.hblank = 1'b0;
    checkOutput("term_queue", expQ.size(), 0);

    $display("[TB] wrap and masking");
    setSrcDst(8'hC0, 8'h0F, 8'hFF, 8'hF0);
    expectBlock(16'hC000, 16'h9FF0, 32);
    base = haltCycles;
    applyStimulus(16'hFF55, 8'h01);
    waitHaltDone(400, "wrap_done");
    checkOutput("wrap_halt", haltCycles - base, 96);
    readReg(16'hFF55, rv); checkOutput("wrap_ff55", int'(rv), 'hFF);
    checkOutput("wrap_queue", expQ.size(), 0);

    $display("[TB] HBlank with LCD off");
    busIf.lcd_on = 1'b0;
    applyStimulus(16'hFF55, 8'h80);
    busIf.hblank = 1'b1;
    idleWindow(60, "lcdoff_no_xfer");
    busIf.hblank = 1'b0;
    busIf.lcd_on = 1'b1;
    applyStimulus(16'hFF55, 8'h00);
    readReg(16'hFF55, rv); checkOutput("lcdoff_ff55", int'(rv), 'h80);

    $display("[TB] ignored source write during GDMA");
    setSrcDst(8'hC3, 8'h00, 8'h03, 8'h00);
    expectBlock(16'hC300, 16'h8300, 16);
    base = haltCycles;
    applyStimulus(16'hFF55, 8'h00);
    applyStimulus(16'hFF51, 8'hD0);
    waitHaltDone(200, "ignore_done");
    checkOutput("ignore_halt", haltCycles - base, 48);
    checkOutput("ignore_queue", expQ.size(), 0);

    $display("[TB] reset mid-GDMA");
    setSrcDst(8'hC4, 8'h00, 8'h04, 8'h00);
    expectBlock(16'hC400, 16'h8400, 5);
    base = writesSeen;
    applyStimulus(16'hFF55, 8'h7F);
    for (int n = 0; n < 100 && writesSeen < base + 5; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("rstmid_writes", writesSeen - base, 5);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_halt", int'(busIf.hdma_halt), 0);
    checkOutput("rstmid_rd", int'(busIf.hdma_rd), 0);
    checkOutput("rstmid_wr", int'(busIf.hdma_wr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    readReg(16'hFF55, rv); checkOutput("rstmid_ff55", int'(rv), 'hFF);
    idleWindow(30, "rstmid_quiet");
    checkOutput("rstmid_queue", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
